// File: rtl/cv32e40p_wb_port_arbiter.sv
// Register-file write port B arbiter.
// Chooses one writer per cycle among LSU load data, buffered APU results
// and a same-cycle APU bypass. A small in-order FIFO holds APU results
// that lose to the LSU, and a starvation counter bounds their wait.
module cv32e40p_wb_port_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_we_i,
    input  logic [ADDR_W-1:0] lsu_waddr_i,
    input  logic [31:0]       lsu_wdata_i,
    output logic              lsu_stall_o,
    input  logic              apu_valid_i,
    input  logic [ADDR_W-1:0] apu_waddr_i,
    input  logic [31:0]       apu_wdata_i,
    output logic              apu_ready_o,
    output logic              regfile_we_o,
    output logic [ADDR_W-1:0] regfile_waddr_o,
    output logic [31:0]       regfile_wdata_o,
    output logic              contention_o,
    output logic [2:0]        buf_count_o,
    output logic              overflow_o
);

    localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]  DEPTH_C  = 3'(DEPTH);
    localparam logic [3:0]  STARVE_C = 4'(STARVE_LIMIT);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_LSU,
        SEL_HEAD,
        SEL_BYPASS
    } sel_e;

    logic [ADDR_W-1:0] r_addr_q [DEPTH];
    logic [31:0]       r_data_q [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [2:0]        r_count;
    logic [3:0]        r_starve;
    logic              r_overflow;

    logic              w_has;
    logic              w_starved;
    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    sel_e              w_sel;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_has     = (r_count != 3'd0);
    assign w_starved = w_has && (r_starve == STARVE_C);
    assign w_ready   = (r_count < DEPTH_C);

    // Priority selection of the single port-B writer for this cycle.
    always_comb begin
        w_sel = SEL_NONE;
        if (w_starved) begin
            w_sel = SEL_HEAD;
        end else if (lsu_we_i) begin
            w_sel = SEL_LSU;
        end else if (w_has) begin
            w_sel = SEL_HEAD;
        end else if (apu_valid_i) begin
            w_sel = SEL_BYPASS;
        end
    end

    assign w_pop  = (w_sel == SEL_HEAD);
    assign w_push = apu_valid_i && w_ready && (w_sel != SEL_BYPASS);

    // Port-B outputs; everything held quiet while reset is asserted.
    always_comb begin
        regfile_we_o    = 1'b0;
        regfile_waddr_o = '0;
        regfile_wdata_o = '0;
        lsu_stall_o     = 1'b0;
        contention_o    = 1'b0;
        if (!rst) begin
            lsu_stall_o  = lsu_we_i && (w_sel != SEL_LSU);
            contention_o = lsu_we_i && (w_has || apu_valid_i);
            case (w_sel)
                SEL_LSU: begin
                    regfile_we_o    = 1'b1;
                    regfile_waddr_o = lsu_waddr_i;
                    regfile_wdata_o = lsu_wdata_i;
                end
                SEL_HEAD: begin
                    regfile_we_o    = 1'b1;
                    regfile_waddr_o = r_addr_q[r_rptr];
                    regfile_wdata_o = r_data_q[r_rptr];
                end
                SEL_BYPASS: begin
                    regfile_we_o    = 1'b1;
                    regfile_waddr_o = apu_waddr_i;
                    regfile_wdata_o = apu_wdata_i;
                end
                default: begin
                    regfile_we_o = 1'b0;
                end
            endcase
        end
    end

    assign apu_ready_o = w_ready;
    assign buf_count_o = r_count;
    assign overflow_o  = r_overflow;

    // Buffer storage: payload needs no reset, validity comes from the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_q[r_wptr] <= apu_waddr_i;
            r_data_q[r_wptr] <= apu_wdata_i;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_next(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_next(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Starvation counter: counts LSU wins while the buffer head waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_pop || !w_has) begin
            r_starve <= '0;
        end else if ((w_sel == SEL_LSU) && (r_starve != STARVE_C)) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    // Sticky flag for APU results dropped on a full buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (apu_valid_i && !w_ready) begin
            r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cv32e40p_wb_port_arbiter.sv
// Directed self-checking bench for cv32e40p_wb_port_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_cv32e40p_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        lsu_we_i;
    logic [5:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_stall_o;
    logic        apu_valid_i;
    logic [5:0]  apu_waddr_i;
    logic [31:0] apu_wdata_i;
    logic        apu_ready_o;
    logic        regfile_we_o;
    logic [5:0]  regfile_waddr_o;
    logic [31:0] regfile_wdata_o;
    logic        contention_o;
    logic [2:0]  buf_count_o;
    logic        overflow_o;

    int checks = 0;
    int errors = 0;

    cv32e40p_wb_port_arbiter #(
        .DEPTH(2),
        .ADDR_W(6),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lsu_we_i(lsu_we_i),
        .lsu_waddr_i(lsu_waddr_i),
        .lsu_wdata_i(lsu_wdata_i),
        .lsu_stall_o(lsu_stall_o),
        .apu_valid_i(apu_valid_i),
        .apu_waddr_i(apu_waddr_i),
        .apu_wdata_i(apu_wdata_i),
        .apu_ready_o(apu_ready_o),
        .regfile_we_o(regfile_we_o),
        .regfile_waddr_o(regfile_waddr_o),
        .regfile_wdata_o(regfile_wdata_o),
        .contention_o(contention_o),
        .buf_count_o(buf_count_o),
        .overflow_o(overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic lwe, input logic [5:0] la, input logic [31:0] ld,
                         input logic av, input logic [5:0] aa, input logic [31:0] ad);
        lsu_we_i    = lwe;
        lsu_waddr_i = la;
        lsu_wdata_i = ld;
        apu_valid_i = av;
        apu_waddr_i = aa;
        apu_wdata_i = ad;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b1, 6'd1, 32'h1, 1'b1, 6'd2, 32'h2);
        #2;
        checks++; if (regfile_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", regfile_we_o); end
        checks++; if (lsu_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", lsu_stall_o); end
        checks++; if (contention_o !== 1'b0) begin errors++; $display("FAIL reset_contention got=%b exp=0", contention_o); end
        checks++; if (regfile_waddr_o !== 6'd0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", regfile_waddr_o); end
        step;
        checks++; if (buf_count_o !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", buf_count_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow_o); end
        checks++; if (apu_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", apu_ready_o); end
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
        rst = 1'b0;
        step;
    endtask

    task automatic test_bypass;
        drive(1'b0, 6'd0, 32'h0, 1'b1, 6'd5, 32'hDEAD_BEEF);
        #1;
        checks++; if (regfile_we_o !== 1'b1) begin errors++; $display("FAIL bypass_we got=%b exp=1", regfile_we_o); end
        checks++; if (regfile_waddr_o !== 6'd5) begin errors++; $display("FAIL bypass_waddr got=%0d exp=5", regfile_waddr_o); end
        checks++; if (regfile_wdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_wdata got=%h exp=deadbeef", regfile_wdata_o); end
        checks++; if (contention_o !== 1'b0) begin errors++; $display("FAIL bypass_contention got=%b exp=0", contention_o); end
        step;
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
        checks++; if (buf_count_o !== 3'd0) begin errors++; $display("FAIL bypass_count got=%0d exp=0", buf_count_o); end
        #1;
        checks++; if (regfile_we_o !== 1'b0) begin errors++; $display("FAIL idle_we got=%b exp=0", regfile_we_o); end
        checks++; if (regfile_wdata_o !== 32'h0) begin errors++; $display("FAIL idle_wdata got=%h exp=0", regfile_wdata_o); end
        step;
    endtask

    task automatic test_contention;
        drive(1'b1, 6'd3, 32'h11, 1'b1, 6'd7, 32'h22);
        #1;
        checks++; if (regfile_waddr_o !== 6'd3) begin errors++; $display("FAIL cont_waddr0 got=%0d exp=3", regfile_waddr_o); end
        checks++; if (regfile_wdata_o !== 32'h11) begin errors++; $display("FAIL cont_wdata0 got=%h exp=11", regfile_wdata_o); end
        checks++; if (contention_o !== 1'b1) begin errors++; $display("FAIL cont_pulse got=%b exp=1", contention_o); end
        checks++; if (lsu_stall_o !== 1'b0) begin errors++; $display("FAIL cont_stall0 got=%b exp=0", lsu_stall_o); end
        step;
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
        #1;
        checks++; if (buf_count_o !== 3'd1) begin errors++; $display("FAIL cont_count1 got=%0d exp=1", buf_count_o); end
        checks++; if (regfile_we_o !== 1'b1) begin errors++; $display("FAIL cont_we1 got=%b exp=1", regfile_we_o); end
        checks++; if (regfile_waddr_o !== 6'd7) begin errors++; $display("FAIL cont_waddr1 got=%0d exp=7", regfile_waddr_o); end
        checks++; if (regfile_wdata_o !== 32'h22) begin errors++; $display("FAIL cont_wdata1 got=%h exp=22", regfile_wdata_o); end
        checks++; if (contention_o !== 1'b0) begin errors++; $display("FAIL cont_pulse1 got=%b exp=0", contention_o); end
        step;
        checks++; if (buf_count_o !== 3'd0) begin errors++; $display("FAIL cont_count2 got=%0d exp=0", buf_count_o); end
    endtask

    task automatic test_starvation;
        // Buffer one result while the LSU takes the port.
        drive(1'b1, 6'd3, 32'h11, 1'b1, 6'd9, 32'h99);
        step;
        drive(1'b1, 6'd10, 32'hA0, 1'b0, 6'd0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++; if (regfile_waddr_o !== 6'd10 || lsu_stall_o !== 1'b0) begin
                errors++; $display("FAIL starve_lsu_win cyc=%0d waddr=%0d stall=%b exp waddr=10 stall=0", k, regfile_waddr_o, lsu_stall_o);
            end
            checks++; if (contention_o !== 1'b1) begin errors++; $display("FAIL starve_contention cyc=%0d got=%b exp=1", k, contention_o); end
            step;
        end
        #1;
        checks++; if (regfile_waddr_o !== 6'd9) begin errors++; $display("FAIL starve_head_waddr got=%0d exp=9", regfile_waddr_o); end
        checks++; if (regfile_wdata_o !== 32'h99) begin errors++; $display("FAIL starve_head_wdata got=%h exp=99", regfile_wdata_o); end
        checks++; if (lsu_stall_o !== 1'b1) begin errors++; $display("FAIL starve_stall got=%b exp=1", lsu_stall_o); end
        step;
        #1;
        checks++; if (regfile_waddr_o !== 6'd10) begin errors++; $display("FAIL starve_after_waddr got=%0d exp=10", regfile_waddr_o); end
        checks++; if (lsu_stall_o !== 1'b0) begin errors++; $display("FAIL starve_after_stall got=%b exp=0", lsu_stall_o); end
        checks++; if (buf_count_o !== 3'd0) begin errors++; $display("FAIL starve_after_count got=%0d exp=0", buf_count_o); end
        step;
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
        step;
    endtask

    task automatic test_order_wrap;
        logic        lsu_pat [12];
        logic [5:0]  apu_pat [12];
        logic [5:0]  exp_q [$];
        int          seen;
        lsu_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        apu_pat = '{6'd20, 6'd21, 6'd0, 6'd22, 6'd0, 6'd23, 6'd0, 6'd24, 6'd25, 6'd0, 6'd0, 6'd0};
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            drive(lsu_pat[c], 6'd40, 32'h4040, apu_pat[c] != 6'd0, apu_pat[c], 32'h1000 + 32'(apu_pat[c]));
            if (apu_pat[c] != 6'd0) exp_q.push_back(apu_pat[c]);
            #1;
            if (regfile_we_o === 1'b1 && regfile_waddr_o !== 6'd40) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL order_unexpected cyc=%0d got=%0d exp=none", c, regfile_waddr_o);
                end else begin
                    if (regfile_waddr_o !== exp_q[0] || regfile_wdata_o !== 32'h1000 + 32'(exp_q[0])) begin
                        errors++; $display("FAIL order_addr cyc=%0d got=%0d/%h exp=%0d", c, regfile_waddr_o, regfile_wdata_o, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                    seen++;
                end
            end
            step;
        end
        checks++; if (seen !== 6) begin errors++; $display("FAIL order_total got=%0d exp=6", seen); end
        checks++; if (buf_count_o !== 3'd0) begin errors++; $display("FAIL order_count got=%0d exp=0", buf_count_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL order_overflow got=%b exp=0", overflow_o); end
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
    endtask

    task automatic test_overflow;
        drive(1'b1, 6'd40, 32'h0, 1'b1, 6'd1, 32'hA1);
        #1;
        checks++; if (apu_ready_o !== 1'b1) begin errors++; $display("FAIL ovf_ready0 got=%b exp=1", apu_ready_o); end
        step;
        checks++; if (buf_count_o !== 3'd1) begin errors++; $display("FAIL ovf_count1 got=%0d exp=1", buf_count_o); end
        drive(1'b1, 6'd40, 32'h0, 1'b1, 6'd2, 32'hA2);
        step;
        checks++; if (buf_count_o !== 3'd2) begin errors++; $display("FAIL ovf_count2 got=%0d exp=2", buf_count_o); end
        checks++; if (apu_ready_o !== 1'b0) begin errors++; $display("FAIL ovf_ready_full got=%b exp=0", apu_ready_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", overflow_o); end
        drive(1'b1, 6'd40, 32'h0, 1'b1, 6'd3, 32'hA3);
        step;
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow_o); end
        checks++; if (buf_count_o !== 3'd2) begin errors++; $display("FAIL ovf_count_hold got=%0d exp=2", buf_count_o); end
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
        #1;
        checks++; if (regfile_waddr_o !== 6'd1) begin errors++; $display("FAIL ovf_drain0 got=%0d exp=1", regfile_waddr_o); end
        step;
        #1;
        checks++; if (regfile_waddr_o !== 6'd2) begin errors++; $display("FAIL ovf_drain1 got=%0d exp=2", regfile_waddr_o); end
        step;
        checks++; if (buf_count_o !== 3'd0) begin errors++; $display("FAIL ovf_drained got=%0d exp=0", buf_count_o); end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow_o); end
    endtask

    task automatic test_async_reset;
        drive(1'b1, 6'd40, 32'h0, 1'b1, 6'd11, 32'hB1);
        step;
        drive(1'b1, 6'd40, 32'h0, 1'b1, 6'd12, 32'hB2);
        step;
        drive(1'b1, 6'd40, 32'h0, 1'b0, 6'd0, 32'h0);
        step;
        step;
        // count=2, starve=3 here; LSU still owns the port
        checks++; if (buf_count_o !== 3'd2 || regfile_we_o !== 1'b1) begin
            errors++; $display("FAIL arst_pre count=%0d we=%b exp count=2 we=1", buf_count_o, regfile_we_o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (regfile_we_o !== 1'b0) begin errors++; $display("FAIL arst_we got=%b exp=0", regfile_we_o); end
        checks++; if (contention_o !== 1'b0) begin errors++; $display("FAIL arst_contention got=%b exp=0", contention_o); end
        checks++; if (buf_count_o !== 3'd0) begin errors++; $display("FAIL arst_count got=%0d exp=0", buf_count_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL arst_overflow got=%b exp=0", overflow_o); end
        #1;
        rst = 1'b0;
        drive(1'b1, 6'd13, 32'hC3, 1'b0, 6'd0, 32'h0);
        #1;
        checks++; if (lsu_stall_o !== 1'b0 || regfile_waddr_o !== 6'd13) begin
            errors++; $display("FAIL arst_lsu stall=%b waddr=%0d exp stall=0 waddr=13", lsu_stall_o, regfile_waddr_o);
        end
        step;
        checks++; if (apu_ready_o !== 1'b1) begin errors++; $display("FAIL arst_ready got=%b exp=1", apu_ready_o); end
        checks++; if (buf_count_o !== 3'd0) begin errors++; $display("FAIL arst_count_after got=%0d exp=0", buf_count_o); end
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
        step;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_contention();
        test_starvation();
        test_order_wrap();
        test_overflow();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cv32e40p_wb_port_arbiter.md
Name: cv32e40p_wb_port_arbiter

Overview:
Arbitrates register-file write port B between LSU load data (WB stage) and APU/FPU results that complete without a free ALU forwarding slot (APU latency class 2+). APU results that lose arbitration are held in a small in-order FIFO. A starvation limit bounds their wait by stalling the LSU writeback. The arbiter sits between the EX/WB pipeline register and the register file, and replaces ad-hoc contention logic with a counted contention event.

Parameters:
DEPTH, 2, APU result buffer entries (1..4)
ADDR_W, 6, register-file write address width
STARVE_LIMIT, 4, consecutive cycles a buffered APU head may lose before it preempts the LSU (1..15)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
lsu_we_i  in  1  LSU requests a write this cycle
lsu_waddr_i  in  ADDR_W  LSU destination register
lsu_wdata_i  in  32  LSU load data
lsu_stall_o  out  1  LSU write not taken this cycle; LSU holds we/addr/data
apu_valid_i  in  1  APU result valid (single-cycle pulse, no backpressure at source)
apu_waddr_i  in  ADDR_W  APU destination register
apu_wdata_i  in  32  APU result
apu_ready_o  out  1  buffer can accept an APU result this cycle
regfile_we_o  out  1  port B write enable
regfile_waddr_o  out  ADDR_W  port B address
regfile_wdata_o  out  32  port B data
contention_o  out  1  perf pulse: LSU and APU (input or buffered) both wanted port B
buf_count_o  out  3  current buffer occupancy
overflow_o  out  1  sticky: APU result arrived with apu_ready_o=0 and was dropped

Behaviour:
- Reset (async, rst=1): count=0, starve=0, FIFO pointers=0, overflow_o=0. regfile_we_o, lsu_stall_o and contention_o are forced 0 while rst=1. waddr/wdata outputs are 0 whenever regfile_we_o=0.
- apu_ready_o = (count < DEPTH), derived from registered count only. A same-cycle dequeue does not make a full buffer ready.
- Port B selection is combinational, one winner per cycle:
  1. count>0 and starve==STARVE_LIMIT: buffer head wins. lsu_stall_o = lsu_we_i.
  2. Else lsu_we_i: LSU wins. lsu_stall_o=0.
  3. Else count>0: buffer head wins.
  4. Else apu_valid_i: APU input is written directly (bypass, 0-cycle latency).
  5. Else regfile_we_o=0.
- Enqueue: apu_valid_i && apu_ready_o && not bypassed → push at tail. The bypass applies only when count==0, so APU results always retire in arrival order.
- Dequeue: the head is popped in any cycle it wins. Simultaneous push and pop: count unchanged, pointers both advance and wrap modulo DEPTH.
- apu_valid_i && !apu_ready_o: result dropped, overflow_o set until reset. count is not modified by the dropped item.
- Starve counter:
  - increments (saturating at STARVE_LIMIT) when count>0 and LSU wins;
  - clears when the head is dequeued or count==0;
  - holds otherwise.
- contention_o = 1 when lsu_we_i and (count>0 or apu_valid_i).
- No address-hazard checking. The ID stage must not issue a dependent read or write against a pending APU destination (apu write-dependency logic covers this).
- Reset asserted mid-operation discards all buffered results. The LSU sees lsu_stall_o=0 from the first cycle after reset.

Test Plan:
- Bypass: idle, apu_valid_i=1, waddr=5, data=0xDEAD_BEEF → same cycle regfile_we_o=1, waddr=5, data=0xDEADBEEF; buf_count_o stays 0.
- Contention: lsu_we_i=1 (r3, 0x11) and apu_valid_i=1 (r7, 0x22) in the same cycle → cycle 0 writes r3 with contention_o=1 and buf_count_o=1 next cycle. Cycle 1 with LSU idle writes r7; count returns to 0.
- Starvation, STARVE_LIMIT=4: one buffered APU result and lsu_we_i held 1 continuously → LSU wins 4 cycles. On the 5th cycle the head is written and lsu_stall_o=1; on the 6th the LSU wins again and starve=0.
- Fill/overflow, DEPTH=2: LSU writes every cycle with starve limit not yet reached, 3 APU pulses → count goes 1, 2 and apu_ready_o=0; the 3rd pulse sets overflow_o=1 and count stays 2.
- Order/wrap: 6 APU results pushed and popped through the 2-entry FIFO while the LSU is intermittent → the addresses written match arrival order exactly, including across pointer wrap.
- Async reset with count=2 and starve=3: assert rst between clock edges → regfile_we_o=0 immediately. After release count=0, overflow_o=0, and apu_ready_o=1.
